reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_sequencer.sv | 93 +++++++++
 tb/tb_reg_op_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: steps a register through clear/load/inc/dec commands, readback CHECK when REG_SEQ_READBACK_EN is defined
module reg_op_sequencer #(
  parameter int NBits = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [NBits-1:0] cmd_data,
  input  logic [3:0]       cmd_count,
  output logic [1:0]       reg_funsel,
  output logic             reg_e,
  output logic [NBits-1:0] reg_i,
  input  logic [NBits-1:0] reg_q,
  output logic [NBits-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);
`ifdef REG_SEQ_READBACK_EN
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
  logic synced;
`else
  typedef enum logic [1:0] {IDLE, ISSUE} state_t;
  logic unused_q;
  assign unused_q = ^reg_q;
  assign mismatch = 1'b0;
`endif
  state_t           state;
  logic [1:0]       op_q;
  logic [NBits-1:0] data_q;
  logic [3:0]       cnt;
  logic             issue;
  logic [NBits-1:0] nxt;
  always_comb begin
    issue      = (state == ISSUE) && rst_n;
    cmd_ready  = (state == IDLE) && rst_n;
    reg_e      = issue;
    reg_funsel = issue ? op_q : 2'b00;
    reg_i      = issue ? data_q : '0;
    busy       = state != IDLE;
    nxt        = op_q == 2'b00 ? '0 :
                 op_q == 2'b01 ? data_q :
                 op_q == 2'b10 ? expected - 1'b1 : expected + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      expected <= '0;
      done     <= 1'b0;
      cnt      <= 4'd0;
`ifdef REG_SEQ_READBACK_EN
      mismatch <= 1'b0;
      synced   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          data_q <= cmd_data;
          cnt    <= cmd_op[1] ? cmd_count : 4'd1;
          if (cmd_op[1] && cmd_count == 4'd0) done <= 1'b1;
          else state <= ISSUE;
        end
        ISSUE: begin
          expected <= nxt;
          cnt      <= cnt - 4'd1;
`ifdef REG_SEQ_READBACK_EN
          state    <= CHECK;
`else
          if (cnt == 4'd1) begin
            state <= IDLE;
            done  <= 1'b1;
          end
`endif
        end
`ifdef REG_SEQ_READBACK_EN
        CHECK: begin
          if (synced && reg_q != expected) mismatch <= 1'b1;
          if (cnt == 4'd0) begin
            state <= IDLE;
            done  <= 1'b1;
            if (!op_q[1]) synced <= 1'b1;
          end else state <= ISSUE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: directed self-checking bench for reg_op_sequencer with an external register model
module tb_reg_op_sequencer;
  localparam int NB = 4;
`ifdef REG_SEQ_READBACK_EN
  localparam int SP = 2;
  localparam int RB = 1;
`else
  localparam int SP = 1;
  localparam int RB = 0;
`endif
  logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [NB-1:0] cmd_data = '0;
  logic [3:0]    cmd_count = 4'd0;
  logic          cmd_ready, reg_e, busy, done, mismatch;
  logic [1:0]    reg_funsel;
  logic [NB-1:0] reg_i, reg_q, expected, q_model, ovr_val = '0;
  logic          ovr = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, e_cnt = 0, d_cnt = 0, b_cnt = 0, bad_gap = 0, idle_bad = 0, last_e = -1;
  logic [1:0]    last_fs = 2'b00;
  logic [NB-1:0] last_i = '0;
  int de, dd, db, lat, e0, d0;

  reg_op_sequencer #(.NBits(NB)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .reg_funsel(reg_funsel), .reg_e(reg_e), .reg_i(reg_i), .reg_q(reg_q),
    .expected(expected), .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  assign reg_q = ovr ? ovr_val : q_model;

  always @(posedge clk)
    q_model <= !rst_n ? '0 : !reg_e ? q_model :
               reg_funsel == 2'b00 ? '0 : reg_funsel == 2'b01 ? reg_i :
               reg_funsel == 2'b10 ? q_model - 1'b1 : q_model + 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reg_e) begin
      e_cnt   <= e_cnt + 1;
      last_fs <= reg_funsel;
      last_i  <= reg_i;
      last_e  <= cyc;
      if (last_e >= 0 && cyc - last_e != SP) bad_gap <= bad_gap + 1;
    end else begin
      if (reg_funsel != 2'b00 || reg_i != '0) idle_bad <= idle_bad + 1;
      if (!busy) last_e <= -1;
    end
    if (done) d_cnt <= d_cnt + 1;
    if (busy) b_cnt <= b_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [NB-1:0] d, input logic [3:0] c);
    int b0;
    @(negedge clk); #1;
    e0 = e_cnt; d0 = d_cnt; b0 = b_cnt;
    cmd_op = op; cmd_data = d; cmd_count = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 0, 1);
    @(negedge clk); #1;
    de = e_cnt - e0; dd = d_cnt - d0; db = b_cnt - b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_reg_e", reg_e, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_expected", expected, 0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", cmd_ready, 1);

    run_cmd(2'b01, 4'b1010, 4'd5);
    check("ld_pulses", de, 1);
    check("ld_funsel", last_fs, 2'b01);
    check("ld_i", last_i, 4'b1010);
    check("ld_expected", expected, 4'b1010);
    check("ld_done", dd, 1);
    check("ld_mismatch", mismatch, 0);
    check("ld_busy", db, SP);
    check("ld_latency", lat, SP + 1);

    run_cmd(2'b01, 4'b1110, 4'd0);
    run_cmd(2'b11, 4'b0000, 4'd3);
    check("inc_pulses", de, 3);
    check("inc_funsel", last_fs, 2'b11);
    check("inc_i", last_i, 4'b0000);
    check("inc_expected_wrap", expected, 4'b0001);
    check("inc_done", dd, 1);
    check("inc_gap", bad_gap, 0);
    check("inc_mismatch", mismatch, 0);

    run_cmd(2'b01, 4'b0001, 4'd0);
    run_cmd(2'b10, 4'b0110, 4'd2);
    check("dec_pulses", de, 2);
    check("dec_funsel", last_fs, 2'b10);
    check("dec_expected_wrap", expected, 4'b1111);
    check("dec_done", dd, 1);
    check("dec_busy", db, 2 * SP);

    ovr_val = 4'b0101; ovr = 1'b1;
    run_cmd(2'b00, 4'b1001, 4'd0);
    ovr = 1'b0;
    check("clr_pulses", de, 1);
    check("clr_expected", expected, 4'b0000);
    check("clr_mismatch", mismatch, RB);
    run_cmd(2'b01, 4'b0011, 4'd0);
    check("sticky_mismatch", mismatch, RB);
    check("sticky_expected", expected, 4'b0011);

    run_cmd(2'b11, 4'b0000, 4'd0);
    check("cnt0_pulses", de, 0);
    check("cnt0_done", dd, 1);
    check("cnt0_latency", lat, 1);
    check("cnt0_expected", expected, 4'b0011);

    @(negedge clk); #1;
    e0 = e_cnt; d0 = d_cnt;
    cmd_op = 2'b11; cmd_count = 4'd8; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); #1;
      if (e_cnt - e0 == 2) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("abort_pulse_timeout", 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_rst_ready", cmd_ready, 0);
    check("abort_rst_reg_e", reg_e, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("abort_rst_busy", busy, 0);
    check("abort_rst_mismatch", mismatch, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("abort_pulses", e_cnt - e0, 2);
    check("abort_done", d_cnt - d0, 0);
    check("abort_expected", expected, 4'b0000);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);

    check("idle_outputs_zero", idle_bad, 0);
    check("pulse_spacing", bad_gap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
